kbd_text_cursor: RTL and testbench

- Downstream stage of the keyboard front end in the character-input interface.
- Consumes the held ASCII code and the non-character key level/code produced by the keyboard decoder.
- Maintains a cursor (row, col) and issues single-cycle writes into the character VRAM that the VGA text renderer reads.
- Handles printable characters, enter, backspace and arrow keys. Clears the screen after reset and clears a row when the cursor wraps onto it.

---
 rtl/kbd_text_pkg.sv | 23 ++
 rtl/kbd_event_gen.sv | 75 +++++++
 rtl/kbd_text_cursor.sv | 168 ++++++++++++++++
 tb/tb_kbd_text_cursor.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_text_pkg.sv
// Shared constants and types for the keyboard text-cursor slice.
// Pure declarations: no logic, no latency, no flow control.
// Holds nonchar key codes, the clear byte, printable bounds and the FSM state enum.
package kbd_text_pkg;

    localparam logic [2:0] KEY_LEFT  = 3'd1;
    localparam logic [2:0] KEY_DOWN  = 3'd2;
    localparam logic [2:0] KEY_UP    = 3'd3;
    localparam logic [2:0] KEY_RIGHT = 3'd4;
    localparam logic [2:0] KEY_ENTER = 3'd5;
    localparam logic [2:0] KEY_BKSP  = 3'd6;

    localparam logic [7:0] CLEAR_CHAR = 8'h00;
    localparam logic [7:0] PRINT_MIN  = 8'h20;
    localparam logic [7:0] PRINT_MAX  = 8'h7E;

    typedef enum logic [1:0] {CLR_ALL, IDLE, CLR_ROW} state_t;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= PRINT_MIN) && (c <= PRINT_MAX);
    endfunction

endpackage

// File: rtl/kbd_event_gen.sv
// Turns held key levels into single-cycle char/nonchar events (optional auto-repeat via KBD_TYPEMATIC_EN).
// Latency: events are combinational against the previous registered sample of the inputs.
// Backpressure: none; the consumer drops events it cannot act on.
module kbd_event_gen
`ifdef KBD_TYPEMATIC_EN
#(
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 2500000
)
`endif
(
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] ascii_in,
    input  logic       nonchar_en,
    input  logic [2:0] nonchar_key,
    output logic       char_evt,
    output logic       nonchar_evt,
    output logic [2:0] key_code
);

    logic [7:0] prev_ascii;
    logic       prev_en;
    logic       char_edge;
    logic       nc_edge;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            prev_ascii <= 8'h00;
            prev_en    <= 1'b0;
        end else begin
            prev_ascii <= ascii_in;
            prev_en    <= nonchar_en;
        end
    end

    assign char_edge = (ascii_in != 8'h00) && (ascii_in != prev_ascii);
    assign nc_edge   = nonchar_en && !prev_en;
    assign key_code  = nonchar_key;

`ifdef KBD_TYPEMATIC_EN
    logic [2:0]  prev_key;
    logic [31:0] hold_cnt;
    logic        char_held;
    logic        nc_held;
    logic        rpt;

    assign char_held = (ascii_in != 8'h00) && (ascii_in == prev_ascii);
    assign nc_held   = nonchar_en && prev_en && (nonchar_key == prev_key);
    assign rpt       = (char_held || nc_held) && (hold_cnt == 32'(REPEAT_DELAY - 1));

    // After the first repeat the counter reloads so it hits the threshold every REPEAT_RATE cycles.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            prev_key <= 3'd0;
            hold_cnt <= 32'd0;
        end else begin
            prev_key <= nonchar_key;
            if (!(char_held || nc_held))
                hold_cnt <= 32'd0;
            else if (rpt)
                hold_cnt <= 32'(REPEAT_DELAY - REPEAT_RATE);
            else
                hold_cnt <= hold_cnt + 32'd1;
        end
    end

    assign nonchar_evt = nc_edge || (rpt && nc_held);
    assign char_evt    = char_edge || (rpt && char_held && !nc_held);
`else
    assign nonchar_evt = nc_edge;
    assign char_evt    = char_edge;
`endif

endmodule

// File: rtl/kbd_text_cursor.sv
// Cursor FSM writing typed characters into text VRAM; clears screen/rows; auto-repeat under KBD_TYPEMATIC_EN.
// Latency: event sampled at edge N -> registered write and cursor update at edge N, wr_en drops at N+1.
// Backpressure: none; events arriving while a clear runs (busy=1) are discarded.
module kbd_text_cursor
    import kbd_text_pkg::*;
#(
    parameter int COLS         = 70,
    parameter int ROWS         = 30,
    parameter int ADDR_W       = 12,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 2500000
)(
    input  logic              clk,
    input  logic              clrn,
    input  logic [7:0]        ascii_in,
    input  logic              nonchar_en,
    input  logic [2:0]        nonchar_key,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [4:0]        cur_row,
    output logic [6:0]        cur_col,
    output logic              busy
);

    localparam int TOTAL = ROWS * COLS;

    logic       char_evt;
    logic       nonchar_evt;
    logic [2:0] key_code;

    kbd_event_gen
`ifdef KBD_TYPEMATIC_EN
    #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    )
`endif
    u_evt (
        .clk         (clk),
        .clrn        (clrn),
        .ascii_in    (ascii_in),
        .nonchar_en  (nonchar_en),
        .nonchar_key (nonchar_key),
        .char_evt    (char_evt),
        .nonchar_evt (nonchar_evt),
        .key_code    (key_code)
    );

    state_t              state_q, state_n;
    logic [ADDR_W-1:0]   clr_q, clr_n;
    logic [4:0]          row_n, row_adv;
    logic [6:0]          col_n;
    logic                wr_en_n;
    logic [ADDR_W-1:0]   wr_addr_n;
    logic [7:0]          wr_data_n;

    function automatic logic [ADDR_W-1:0] addr_of(input logic [4:0] r, input logic [6:0] c);
        return ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
    endfunction

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= CLR_ALL;
            clr_q   <= '0;
            cur_row <= 5'd0;
            cur_col <= 7'd0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= 8'h00;
            busy    <= 1'b1;
        end else begin
            state_q <= state_n;
            clr_q   <= clr_n;
            cur_row <= row_n;
            cur_col <= col_n;
            wr_en   <= wr_en_n;
            wr_addr <= wr_addr_n;
            wr_data <= wr_data_n;
            busy    <= (state_n != IDLE);
        end
    end

    assign row_adv = (cur_row == 5'(ROWS - 1)) ? 5'd0 : cur_row + 5'd1;

    always_comb begin
        state_n   = state_q;
        clr_n     = clr_q;
        row_n     = cur_row;
        col_n     = cur_col;
        wr_en_n   = 1'b0;
        wr_addr_n = wr_addr;
        wr_data_n = wr_data;
        case (state_q)
            CLR_ALL: begin
                wr_en_n   = 1'b1;
                wr_addr_n = clr_q;
                wr_data_n = CLEAR_CHAR;
                if (clr_q == ADDR_W'(TOTAL - 1)) begin
                    state_n = IDLE;
                    clr_n   = '0;
                end else begin
                    clr_n = clr_q + 1'b1;
                end
            end
            CLR_ROW: begin
                wr_en_n   = 1'b1;
                wr_addr_n = addr_of(cur_row, 7'd0) + clr_q;
                wr_data_n = CLEAR_CHAR;
                if (clr_q == ADDR_W'(COLS - 1)) begin
                    state_n = IDLE;
                    clr_n   = '0;
                end else begin
                    clr_n = clr_q + 1'b1;
                end
            end
            IDLE: begin
                // A nonchar event in the same cycle as a char event takes priority.
                if (nonchar_evt) begin
                    case (key_code)
                        KEY_LEFT:  if (cur_col != 7'd0) col_n = cur_col - 7'd1;
                        KEY_RIGHT: if (cur_col < 7'(COLS - 1)) col_n = cur_col + 7'd1;
                        KEY_UP:    if (cur_row != 5'd0) row_n = cur_row - 5'd1;
                        KEY_DOWN:  if (cur_row < 5'(ROWS - 1)) row_n = cur_row + 5'd1;
                        KEY_ENTER: begin
                            col_n   = 7'd0;
                            row_n   = row_adv;
                            state_n = CLR_ROW;
                            clr_n   = '0;
                        end
                        KEY_BKSP: begin
                            if (cur_col != 7'd0) begin
                                col_n     = cur_col - 7'd1;
                                wr_en_n   = 1'b1;
                                wr_addr_n = addr_of(cur_row, cur_col - 7'd1);
                                wr_data_n = CLEAR_CHAR;
                            end else if (cur_row != 5'd0) begin
                                row_n     = cur_row - 5'd1;
                                col_n     = 7'(COLS - 1);
                                wr_en_n   = 1'b1;
                                wr_addr_n = addr_of(cur_row - 5'd1, 7'(COLS - 1));
                                wr_data_n = CLEAR_CHAR;
                            end
                        end
                        default: ;
                    endcase
                end else if (char_evt && is_printable(ascii_in)) begin
                    wr_en_n   = 1'b1;
                    wr_addr_n = addr_of(cur_row, cur_col);
                    wr_data_n = ascii_in;
                    if (cur_col < 7'(COLS - 1)) begin
                        col_n = cur_col + 7'd1;
                    end else begin
                        col_n   = 7'd0;
                        row_n   = row_adv;
                        state_n = CLR_ROW;
                        clr_n   = '0;
                    end
                end
            end
            default: begin
                state_n = CLR_ALL;
                clr_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_kbd_text_cursor.sv
// Directed plus randomized bench for kbd_text_cursor with a screen/cursor reference model.
module tb_kbd_text_cursor;

    localparam int COLS = 4;
    localparam int ROWS = 3;
    localparam int AW   = 12;
    localparam int RD   = 20;
    localparam int RR   = 5;

    logic          clk = 1'b0;
    logic          clrn = 1'b0;
    logic [7:0]    ascii_in = 8'h00;
    logic          nonchar_en = 1'b0;
    logic [2:0]    nonchar_key = 3'd0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [4:0]    cur_row;
    logic [6:0]    cur_col;
    logic          busy;

    kbd_text_cursor #(
        .COLS(COLS), .ROWS(ROWS), .ADDR_W(AW), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk(clk), .clrn(clrn), .ascii_in(ascii_in), .nonchar_en(nonchar_en),
        .nonchar_key(nonchar_key), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cur_row(cur_row), .cur_col(cur_col), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int got[$];
    int exp_q[$];
    int scr_model [ROWS*COLS];
    int scr_dut   [ROWS*COLS];
    int m_row = 0;
    int m_col = 0;

    // Write log entries are encoded as addr*256 + data.
    always @(negedge clk) begin
        if (clrn && wr_en === 1'b1) begin
            got.push_back(int'(wr_addr) * 256 + int'(wr_data));
            if (int'(wr_addr) < ROWS*COLS) scr_dut[int'(wr_addr)] = int'(wr_data);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got=%0d required=done", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic m_write(input int a, input int d);
        exp_q.push_back(a * 256 + d);
        scr_model[a] = d;
    endtask

    task automatic m_adv_row();
        m_col = 0;
        m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
        for (int c = 0; c < COLS; c++) m_write(m_row * COLS + c, 0);
    endtask

    task automatic m_char(input int c);
        if (c >= 32 && c <= 126) begin
            m_write(m_row * COLS + m_col, c);
            if (m_col < COLS - 1) m_col++;
            else m_adv_row();
        end
    endtask

    task automatic m_nc(input int k);
        case (k)
            1: if (m_col > 0) m_col--;
            2: if (m_row < ROWS - 1) m_row++;
            3: if (m_row > 0) m_row--;
            4: if (m_col < COLS - 1) m_col++;
            5: m_adv_row();
            6: begin
                if (m_col > 0) begin
                    m_col--;
                    m_write(m_row * COLS + m_col, 0);
                end else if (m_row > 0) begin
                    m_row--;
                    m_col = COLS - 1;
                    m_write(m_row * COLS + m_col, 0);
                end
            end
            default: ;
        endcase
    endtask

    task automatic m_clear_all();
        m_row = 0;
        m_col = 0;
        for (int a = 0; a < ROWS*COLS; a++) m_write(a, 0);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic press_char(input int c, input int hold);
        @(negedge clk);
        ascii_in = 8'(c);
        repeat (hold) @(negedge clk);
        ascii_in = 8'h00;
    endtask

    task automatic press_nc(input int k, input int hold);
        @(negedge clk);
        nonchar_en  = 1'b1;
        nonchar_key = 3'(k);
        repeat (hold) @(negedge clk);
        nonchar_en = 1'b0;
    endtask

    task automatic settle(input string tag);
        int t;
        t = 0;
        repeat (2) @(negedge clk);
        while (busy !== 1'b0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check({tag, ":idle"}, 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    task automatic compare(input string tag);
        check({tag, ":nwr"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check($sformatf("%s:wr%0d(addr*256+data)", tag, i), got[i], exp_q[i]);
        check({tag, ":row"}, 32'(cur_row), m_row);
        check({tag, ":col"}, 32'(cur_col), m_col);
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        int op, c, k, h;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst:wr_en",   32'(wr_en),   32'd0);
        check("rst:wr_addr", 32'(wr_addr), 32'd0);
        check("rst:wr_data", 32'(wr_data), 32'd0);
        check("rst:row",     32'(cur_row), 32'd0);
        check("rst:col",     32'(cur_col), 32'd0);
        check("rst:busy",    32'(busy),    32'd1);

        // Power-up clear of the whole screen
        m_clear_all();
        clrn = 1'b1;
        @(negedge clk);
        check("clr_all:busy_running", 32'(busy), 32'd1);
        settle("clr_all");
        compare("clr_all");

        // Held key produces one write
        press_char(8'h41, 10);
        m_char(8'h41);
        settle("hold_a");
        compare("hold_a");

        // Back to origin, then type a line that overflows
        press_nc(6, 1); m_nc(6); settle("bk0");
        for (int i = 0; i < 4; i++) begin
            press_char(8'h61 + i, 1);
            m_char(8'h61 + i);
            settle("type");
        end
        compare("line_wrap");

        // Backspace across a row boundary
        press_nc(6, 1); m_nc(6); settle("bk_wrap");
        compare("bk_wrap");

        // Arrows to (2,2), then enter wraps to row 0 and clears it
        press_nc(2, 1); m_nc(2); settle("down1");
        press_nc(2, 1); m_nc(2); settle("down2");
        press_nc(1, 1); m_nc(1); settle("left1");
        compare("arrows");
        press_nc(5, 1); m_nc(5); settle("enter_wrap");
        compare("enter_wrap");
        press_nc(6, 1); m_nc(6); settle("bk_origin");
        compare("bk_origin");
        for (int i = 0; i < 5; i++) begin
            press_nc(4, 1); m_nc(4); settle("right");
        end
        compare("right_sat");

        // Enter to (1,0), then nonchar and char events in the same cycle
        press_nc(5, 1); m_nc(5); settle("enter2");
        @(negedge clk);
        ascii_in = 8'h41; nonchar_en = 1'b1; nonchar_key = 3'd6;
        repeat (2) @(negedge clk);
        ascii_in = 8'h00; nonchar_en = 1'b0;
        m_nc(6);
        settle("both");
        compare("both_evt");

        // Long hold from origin
        for (int i = 0; i < 3; i++) begin
            press_nc(1, 1); m_nc(1); settle("left");
        end
        press_char(8'h41, 32);
        m_char(8'h41);
`ifdef KBD_TYPEMATIC_EN
        for (int t = RD; t < 32; t += RR) m_char(8'h41);
`endif
        settle("long_hold");
        compare("long_hold");

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            op = $urandom_range(0, 9);
            h  = $urandom_range(1, 3);
            if (op <= 4) begin
                c = $urandom_range(32, 126);
                press_char(c, h);
                m_char(c);
            end else if (op == 5) begin
                c = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 31) : $urandom_range(127, 255);
                press_char(c, h);
                m_char(c);
            end else begin
                k = $urandom_range(0, 7);
                press_nc(k, h);
                m_nc(k);
            end
            settle($sformatf("rnd%0d", n));
            compare($sformatf("rnd%0d", n));
        end
        for (int a = 0; a < ROWS*COLS; a++)
            check($sformatf("screen[%0d]", a), scr_dut[a], scr_model[a]);

        // Reset in the middle of a row clear restarts the full clear
        @(negedge clk);
        nonchar_en = 1'b1; nonchar_key = 3'd5;
        @(negedge clk);
        nonchar_en = 1'b0;
        @(negedge clk);
        #2 clrn = 1'b0;
        #1;
        check("midrst:busy",  32'(busy),    32'd1);
        check("midrst:wr_en", 32'(wr_en),   32'd0);
        check("midrst:row",   32'(cur_row), 32'd0);
        check("midrst:col",   32'(cur_col), 32'd0);
        got.delete();
        exp_q.delete();
        m_clear_all();
        @(negedge clk);
        clrn = 1'b1;
        settle("midrst");
        compare("midrst_clear");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
